// File: rtl/conv3x3_pkg.sv
// conv3x3_pkg: shared types and constants for the 3x3 tap sequencer slice.
//   state_t - sequencer FSM states
//   TAPS    - taps per window (3x3)
//   TAP_CW  - width of tap index / counter
//   lat_cw  - width of a counter that must hold values 0..lat
package conv3x3_pkg;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_STREAM = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESULT = 2'd3
  } state_t;

  localparam int unsigned TAPS   = 9;
  localparam int unsigned TAP_CW = 4;

  function automatic int unsigned lat_cw(input int unsigned lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/conv3x3_tap_buffer.sv
// conv3x3_tap_buffer: 9-entry (pixel, weight) register file.
// Ports:
//   i_clk              - clock
//   i_we               - write enable
//   i_wr_idx           - write index (0..8; larger indices are dropped)
//   i_wr_x, i_wr_w     - write data
//   i_rd_idx           - read index (0..8; larger indices read as zero)
//   o_rd_x, o_rd_w     - combinational read data
// Contents are not reset; a window always rewrites all nine entries before use.
module conv3x3_tap_buffer
  import conv3x3_pkg::*;
#(
  parameter int unsigned X_BW = 8,
  parameter int unsigned W_BW = 8
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [TAP_CW-1:0]        i_wr_idx,
  input  logic signed [X_BW-1:0]   i_wr_x,
  input  logic signed [W_BW-1:0]   i_wr_w,
  input  logic [TAP_CW-1:0]        i_rd_idx,
  output logic signed [X_BW-1:0]   o_rd_x,
  output logic signed [W_BW-1:0]   o_rd_w
);

  localparam logic [TAP_CW-1:0] NTAPS = TAP_CW'(TAPS);

  logic signed [X_BW-1:0] x_mem [TAPS];
  logic signed [W_BW-1:0] w_mem [TAPS];

  always_ff @(posedge i_clk) begin
    if (i_we && (i_wr_idx < NTAPS)) begin
      x_mem[i_wr_idx] <= i_wr_x;
      w_mem[i_wr_idx] <= i_wr_w;
    end
  end

  always_comb begin
    o_rd_x = '0;
    o_rd_w = '0;
    if (i_rd_idx < NTAPS) begin
      o_rd_x = x_mem[i_rd_idx];
      o_rd_w = w_mem[i_rd_idx];
    end
  end

endmodule

// File: rtl/conv3x3_tap_sequencer.sv
// conv3x3_tap_sequencer: loads nine (pixel, weight) taps plus a partial sum,
// streams them one per cycle into a serial 3x3 convolution engine, waits the
// engine latency and hands the captured engine output out on a result port.
// Ports:
//   i_clk, i_rst                 - clock, async active-high reset
//   i_ld_valid/o_ld_ready        - load handshake
//   i_ld_x, i_ld_w, i_ld_psum    - load beat data (psum sampled on beat 0)
//   o_x, o_w, o_psum             - registered engine inputs (zero outside STREAM)
//   i_y                          - engine output
//   o_res_valid/i_res_ready      - result handshake
//   o_res_data                   - captured engine result
//   o_busy                       - high whenever not in LOAD
module conv3x3_tap_sequencer
  import conv3x3_pkg::*;
#(
  parameter int unsigned X_BW = 8,
  parameter int unsigned W_BW = 8,
  parameter int unsigned I_BW = 19,
  parameter int unsigned O_BW = 19,
  parameter int unsigned LAT  = 10
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_ld_valid,
  output logic                     o_ld_ready,
  input  logic signed [X_BW-1:0]   i_ld_x,
  input  logic signed [W_BW-1:0]   i_ld_w,
  input  logic signed [I_BW-1:0]   i_ld_psum,
  output logic signed [X_BW-1:0]   o_x,
  output logic signed [W_BW-1:0]   o_w,
  output logic signed [I_BW-1:0]   o_psum,
  input  logic signed [O_BW-1:0]   i_y,
  output logic                     o_res_valid,
  output logic signed [O_BW-1:0]   o_res_data,
  input  logic                     i_res_ready,
  output logic                     o_busy
);

  localparam int unsigned       LCW       = lat_cw(LAT);
  localparam logic [TAP_CW-1:0] LAST_TAP  = TAP_CW'(TAPS - 1);
  localparam logic [LCW-1:0]    LAST_WAIT = LCW'(LAT - 1);

  state_t                  state;
  logic [TAP_CW-1:0]       tap_cnt;
  logic [LCW-1:0]          wait_cnt;
  logic signed [I_BW-1:0]  psum_q;

  logic                    buf_we;
  logic [TAP_CW-1:0]       rd_idx;
  logic signed [X_BW-1:0]  rd_x;
  logic signed [W_BW-1:0]  rd_w;

  assign o_ld_ready = (state == ST_LOAD);
  assign o_busy     = (state != ST_LOAD);
  assign buf_we     = (state == ST_LOAD) && i_ld_valid;

  // Output taps are registered, so the buffer is read one tap ahead: tap 0
  // while loading (loaded into o_x/o_w on the final beat), tap k+1 during
  // stream cycle k.
  assign rd_idx = (state == ST_STREAM) ? tap_cnt + TAP_CW'(1) : '0;

  conv3x3_tap_buffer #(
    .X_BW (X_BW),
    .W_BW (W_BW)
  ) u_buf (
    .i_clk    (i_clk),
    .i_we     (buf_we),
    .i_wr_idx (tap_cnt),
    .i_wr_x   (i_ld_x),
    .i_wr_w   (i_ld_w),
    .i_rd_idx (rd_idx),
    .o_rd_x   (rd_x),
    .o_rd_w   (rd_w)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= ST_LOAD;
      tap_cnt     <= '0;
      wait_cnt    <= '0;
      psum_q      <= '0;
      o_x         <= '0;
      o_w         <= '0;
      o_psum      <= '0;
      o_res_valid <= 1'b0;
      o_res_data  <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (i_ld_valid) begin
            if (tap_cnt == '0) begin
              psum_q <= i_ld_psum;
            end
            if (tap_cnt == LAST_TAP) begin
              tap_cnt <= '0;
              o_x     <= rd_x;
              o_w     <= rd_w;
              o_psum  <= psum_q;
              state   <= ST_STREAM;
            end else begin
              tap_cnt <= tap_cnt + TAP_CW'(1);
            end
          end
        end
        ST_STREAM: begin
          if (tap_cnt == LAST_TAP) begin
            tap_cnt  <= '0;
            wait_cnt <= '0;
            o_x      <= '0;
            o_w      <= '0;
            o_psum   <= '0;
            state    <= ST_WAIT;
          end else begin
            tap_cnt <= tap_cnt + TAP_CW'(1);
            o_x     <= rd_x;
            o_w     <= rd_w;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == LAST_WAIT) begin
            wait_cnt    <= '0;
            o_res_data  <= i_y;
            o_res_valid <= 1'b1;
            state       <= ST_RESULT;
          end else begin
            wait_cnt <= wait_cnt + LCW'(1);
          end
        end
        ST_RESULT: begin
          if (i_res_ready) begin
            o_res_valid <= 1'b0;
            state       <= ST_LOAD;
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule
